iport_debouncer: RTL and testbench



---
 rtl/cdec_io_pkg.sv | 21 ++
 rtl/debounce_bit.sv | 72 +++++++
 rtl/iport_debouncer.sv | 35 +++
 tb/tb_iport_debouncer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cdec_io_pkg.sv
// Shared constants for the cdec I/O block and a counter-width helper
// used by the input debouncer.
package cdec_io_pkg;

  localparam int IO_WIDTH             = 8;
  localparam int DEBOUNCE_CYCLES_SIM  = 16;
  localparam int DEBOUNCE_CYCLES_FPGA = 500000;

  // Stability counter width: max(1, clog2(n)) so n=1 still gets a legal vector.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchronizer, stability counter and one-cycle
// rise/fall pulses that coincide with the accepted change.
module debounce_bit
  import cdec_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          rise_r;
  logic          fall_r;
  logic [CW-1:0] cnt_r;

  logic          stable_s;
  logic          rise_s;
  logic          fall_s;
  logic [CW-1:0] cnt_s;

  // Next-state: count while the synchronized level differs, accept at CNT_MAX.
  always_comb begin
    stable_s = stable_r;
    cnt_s    = cnt_r;
    rise_s   = 1'b0;
    fall_s   = 1'b0;
    if (sync2_r == stable_r) begin
      cnt_s = '0;
    end else if (cnt_r == CNT_MAX) begin
      stable_s = sync2_r;
      cnt_s    = '0;
      rise_s   = sync2_r;
      fall_s   = ~sync2_r;
    end else begin
      cnt_s = cnt_r + CW'(1);
    end
  end

  // Synchronizer, debounce state and registered edge pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= '0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else begin
      sync1_r  <= raw;
      sync2_r  <= sync1_r;
      stable_r <= stable_s;
      cnt_r    <= cnt_s;
      rise_r   <= rise_s;
      fall_r   <= fall_s;
    end
  end

  assign stable = stable_r;
  assign rise   = rise_r;
  assign fall   = fall_r;

endmodule

// File: rtl/iport_debouncer.sv
// Debounces the raw board input pins feeding io_device.iport and
// reports per-bit press/release pulses plus a combined change pulse.
module iport_debouncer
  import cdec_io_pkg::*;
#(
  parameter int WIDTH           = IO_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] iport_raw,
  output logic [WIDTH-1:0] iport,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (iport_raw[i]),
      .stable (iport[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  // Built only from flop outputs so it lands in the same cycle as the pulses
  // and has no path back to iport_raw.
  assign changed = |(rise | fall);

endmodule

// File: tb/tb_iport_debouncer.sv
// Directed bench: N=16 instance for reset, step, glitch, multi-bit and
// mid-count reset; N=1 instance for the unfiltered boundary case.
module tb_iport_debouncer;

  logic       clock;
  logic       reset_n;
  logic [7:0] iport_raw;
  logic [7:0] iport;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       changed;
  logic [7:0] raw1;
  logic [7:0] iport1;
  logic [7:0] rise1;
  logic [7:0] fall1;
  logic       changed1;

  int compared;
  int mismatched;
  int rc;

  iport_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n), .iport_raw(iport_raw),
    .iport(iport), .rise(rise), .fall(fall), .changed(changed)
  );

  iport_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .iport_raw(raw1),
    .iport(iport1), .rise(rise1), .fall(fall1), .changed(changed1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    iport_raw  = 8'hFF;
    raw1       = 8'h00;

    // Reset with all pins high
    tick(3);
    chk("rst_iport", iport, 8'h00);
    chk("rst_rise", rise, 8'h00);
    chk("rst_changed", {7'd0, changed}, 8'h00);
    reset_n = 1'b1;
    tick(17);
    chk("rst_e17_iport", iport, 8'h00);
    tick(1);
    chk("rst_e18_iport", iport, 8'hFF);
    chk("rst_e18_rise", rise, 8'hFF);
    chk("rst_e18_fall", fall, 8'h00);
    chk("rst_e18_changed", {7'd0, changed}, 8'h01);
    tick(1);
    chk("rst_e19_rise", rise, 8'h00);
    chk("rst_e19_changed", {7'd0, changed}, 8'h00);

    // Drop everything back to zero
    iport_raw = 8'h00;
    tick(18);
    chk("clr_iport", iport, 8'h00);
    chk("clr_fall", fall, 8'hFF);
    tick(1);

    // Clean step on bit 0
    iport_raw = 8'h01;
    for (int i = 1; i <= 19; i++) begin
      tick(1);
      chk("step_fall", fall, 8'h00);
      if (i == 17) chk("step_e17_iport", iport, 8'h00);
      if (i == 18) begin
        chk("step_e18_iport", iport, 8'h01);
        chk("step_e18_rise", rise, 8'h01);
        chk("step_e18_changed", {7'd0, changed}, 8'h01);
      end
      if (i == 19) chk("step_e19_rise", rise, 8'h00);
    end

    // Glitch of 10 cycles on bit 2 is rejected
    iport_raw = 8'h05;
    tick(10);
    iport_raw = 8'h01;
    for (int i = 0; i < 20; i++) begin
      chk("glitch_iport", iport, 8'h01);
      chk("glitch_rise", rise, 8'h00);
      tick(1);
    end

    // 16-cycle pulse on bit 2 is accepted, exactly one rise
    rc = 0;
    iport_raw = 8'h05;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (i == 16) iport_raw = 8'h01;
      if (i == 17) chk("pulse_e17_iport", iport, 8'h01);
      if (i == 18) begin
        chk("pulse_e18_iport", iport, 8'h05);
        chk("pulse_e18_rise", rise, 8'h04);
      end
      rc += int'(rise[2]);
    end
    chk("pulse_rise_count", rc[7:0], 8'd1);
    chk("pulse_end_iport", iport, 8'h01);

    // Bit 0 falls and bit 7 rises together
    iport_raw = 8'h80;
    tick(17);
    chk("multi_e17_iport", iport, 8'h01);
    tick(1);
    chk("multi_iport", iport, 8'h80);
    chk("multi_rise", rise, 8'h80);
    chk("multi_fall", fall, 8'h01);
    chk("multi_changed", {7'd0, changed}, 8'h01);
    tick(1);
    chk("multi_after_changed", {7'd0, changed}, 8'h00);
    chk("multi_after_pulses", rise | fall, 8'h00);

    // Reset 10 cycles into a rise on bit 3
    iport_raw = 8'h88;
    tick(10);
    reset_n = 1'b0;
    #2;
    chk("midrst_iport", iport, 8'h00);
    chk("midrst_rise", rise, 8'h00);
    chk("midrst_fall", fall, 8'h00);
    chk("midrst_changed", {7'd0, changed}, 8'h00);
    tick(2);
    reset_n = 1'b1;
    tick(17);
    chk("midrst_e17_iport", iport, 8'h00);
    tick(1);
    chk("midrst_e18_iport", iport, 8'h88);
    chk("midrst_e18_rise", rise, 8'h88);

    // N=1: single-cycle raw pulse on bit 5
    raw1 = 8'h20;
    tick(1);
    raw1 = 8'h00;
    tick(1);
    chk("n1_e2_iport", iport1, 8'h00);
    tick(1);
    chk("n1_e3_iport", iport1, 8'h20);
    chk("n1_e3_rise", rise1, 8'h20);
    chk("n1_e3_fall", fall1, 8'h00);
    chk("n1_e3_changed", {7'd0, changed1}, 8'h01);
    tick(1);
    chk("n1_e4_iport", iport1, 8'h00);
    chk("n1_e4_rise", rise1, 8'h00);
    chk("n1_e4_fall", fall1, 8'h20);
    tick(1);
    chk("n1_e5_fall", fall1, 8'h00);
    chk("n1_e5_changed", {7'd0, changed1}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
